// File: rtl/charge_link_sequencer.sv
// charge_link_sequencer: SMPS frame evaluation, charge-state FSM, dual-link byte serialiser and link watchdog
module charge_link_sequencer #(
  parameter logic [7:0] V_PANEL_MIN = 8'd60,
  parameter logic [7:0] V_CAP_FULL  = 8'd200,
  parameter logic [7:0] V_CAP_MAX   = 8'd230,
  parameter logic [7:0] HYST        = 8'd10,
  parameter logic [7:0] I_TARGET    = 8'd128,
  parameter logic [9:0] VAL_INIT    = 10'd256,
  parameter logic [9:0] VAL_STEP    = 10'd8,
  parameter int         TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [23:0] rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_dest,
  output logic        tx_last,
  output logic [7:0]  V_panel,
  output logic [7:0]  I_panel,
  output logic [7:0]  V_cap,
  output logic [2:0]  state,
  output logic [9:0]  val,
  output logic        charge_on,
  output logic        frame_drop,
  output logic        timeout_flag
);
  typedef enum logic [2:0] {IDLE = 3'd0, CHARGE, TOPOFF, FULL, FAULT} chg_t;
  typedef enum logic [1:0] {P_WAIT, P_EVAL, P_SEND} ph_t;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  ph_t ph;
  chg_t st, n_st;
  logic [9:0] n_val, v_up, v_dn;
  logic [23:0] cur, pend;
  logic pend_v, to_pend, take, wd_hit, go_idle, low, go_full;
  logic [WW-1:0] wd;
  logic [2:0] idx;
  logic [7:0] vp, ip, vc, hi;
  assign {vp, ip, vc} = cur;
  assign state = st;
  assign v_up = (val > 10'd1023 - VAL_STEP) ? 10'd1023 : val + VAL_STEP;
  assign v_dn = (val < VAL_STEP) ? 10'd0 : val - VAL_STEP;
  assign go_idle = vp >= V_PANEL_MIN && vc < V_CAP_FULL;
  assign low = vc < V_CAP_FULL - HYST;
  assign go_full = low && vp >= V_PANEL_MIN;
  assign wd_hit = wd == WW'(TIMEOUT_CYC - 1);
  assign take = ph == P_SEND && tx_ready && idx == 3'd4 && pend_v;
  assign hi = {3'b0, st, val[9:8]};
  assign tx_valid = ph == P_SEND;
  assign tx_dest = idx >= 3'd3;
  assign tx_last = idx == 3'd4;
  assign tx_data = idx == 3'd0 ? 8'd0 : (idx == 3'd1 || idx == 3'd3) ? hi : val[7:0];
  always_comb begin
    n_st = st;
    n_val = val;
    if (vc >= V_CAP_MAX) begin
      n_st = FAULT;
      n_val = '0;
    end else if (st == FAULT && !timeout_flag) begin
      n_st = vc < V_CAP_FULL ? IDLE : FAULT;
      n_val = '0;
    end else if (st == IDLE || st == FAULT) begin
      n_st = go_idle ? CHARGE : IDLE;
      n_val = go_idle ? VAL_INIT : '0;
    end else if (st == CHARGE) begin
      if (vc >= V_CAP_FULL) n_st = TOPOFF;
      else if (vp < V_PANEL_MIN) begin
        n_st = IDLE;
        n_val = '0;
      end else n_val = ip < I_TARGET ? v_up : ip > I_TARGET ? v_dn : val;
    end else if (st == TOPOFF) begin
      n_st = low ? CHARGE : v_dn == '0 ? FULL : TOPOFF;
      n_val = low ? val : v_dn;
    end else begin
      n_st = go_full ? CHARGE : FULL;
      n_val = go_full ? VAL_INIT : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= P_WAIT;
      st <= IDLE;
      val <= '0;
      cur <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      to_pend <= 1'b0;
      wd <= '0;
      idx <= '0;
      {V_panel, I_panel, V_cap} <= '0;
      charge_on <= 1'b0;
      frame_drop <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      wd <= (rx_valid || wd_hit) ? '0 : wd + WW'(1);
      case (ph)
        P_WAIT:
          if (rx_valid) begin
            cur <= rx_data;
            to_pend <= 1'b0;
            ph <= P_EVAL;
          end else if (wd_hit || to_pend) begin
            st <= FAULT;
            val <= '0;
            charge_on <= 1'b0;
            timeout_flag <= 1'b1;
            to_pend <= 1'b0;
            idx <= '0;
            ph <= P_SEND;
          end
        P_EVAL: begin
          st <= n_st;
          val <= n_val;
          charge_on <= n_st == CHARGE || n_st == TOPOFF;
          timeout_flag <= 1'b0;
          {V_panel, I_panel, V_cap} <= cur;
          idx <= '0;
          ph <= P_SEND;
        end
        default:
          if (tx_ready) begin
            idx <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
            if (idx == 3'd4) ph <= pend_v ? P_EVAL : P_WAIT;
            if (take) begin
              cur <= pend;
              pend_v <= 1'b0;
              to_pend <= 1'b0;
            end
          end
      endcase
      if (ph != P_WAIT) begin
        if (wd_hit && !rx_valid && !take) to_pend <= 1'b1;
        if (rx_valid) begin
          pend <= rx_data;
          pend_v <= 1'b1;
          frame_drop <= pend_v && !take;
        end
      end
    end
  end
endmodule
